// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default frame geometry and a small elaboration-time helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } rx_state_t;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_SB_TICKS   = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous input; resets to a
// configurable idle level so the downstream logic sees a quiet line.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1,
   parameter int   STAGES    = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_reg <= {STAGES{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first 8N1 deserializer with a
// one-cycle done pulse and a coincident framing-error pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int SB_TICKS   = DEF_SB_TICKS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_s_tick,
   input  logic                 i_rx,
   output logic                 o_rx_done,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_frame_err
);

   localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICKS));
   localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_reg, state_next;
   logic [SW-1:0]        s_reg, s_next;
   logic [NW-1:0]        n_reg, n_next;
   logic [DATA_BITS-1:0] b_reg, b_next;
   logic [DATA_BITS-1:0] data_reg, data_next;
   logic                 done_reg, done_next;
   logic                 ferr_reg, ferr_next;

   sync_2ff #(
      .RESET_VAL (1'b1),
      .STAGES    (2)
   ) u_rx_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         data_reg  <= '0;
         done_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         data_reg  <= data_next;
         done_reg  <= done_next;
         ferr_reg  <= ferr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      data_next  = data_reg;
      done_next  = 1'b0;
      ferr_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            // Start-bit detection does not wait for a tick.
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end

         START: begin
            if (i_s_tick) begin
               if (s_reg == S_HALF) begin
                  // Mid-start-bit recheck rejects short low glitches.
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end

         DATA: begin
            if (i_s_tick) begin
               if (s_reg == S_BIT) begin
                  s_next = '0;
                  b_next = {rx_s, b_reg[DATA_BITS-1:1]};
                  if (n_reg == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_next = n_reg + 1'b1;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end

         STOP: begin
            if (i_s_tick) begin
               if (s_reg == S_STOP) begin
                  // Data is delivered even when the stop bit is bad.
                  data_next  = b_reg;
                  done_next  = 1'b1;
                  ferr_next  = ~rx_s;
                  s_next     = '0;
                  state_next = IDLE;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign o_rx_done   = done_reg;
   assign o_data      = data_reg;
   assign o_frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven on a 4-clock tick grid,
// received bytes captured by a monitor and compared to hand values.
module tb_uart_rx;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_s_tick = 1'b0;
   logic       i_rx = 1'b1;
   logic       o_rx_done;
   logic [7:0] o_data;
   logic       o_frame_err;

   always #5 i_clk = ~i_clk;

   uart_rx dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_s_tick    (i_s_tick),
      .i_rx        (i_rx),
      .o_rx_done   (o_rx_done),
      .o_data      (o_data),
      .o_frame_err (o_frame_err)
   );

   // Oversample tick: one cycle high every 4 clocks while enabled.
   logic       tick_en = 1'b0;
   logic [1:0] tick_cnt = 2'd0;
   always @(posedge i_clk) begin
      if (!tick_en) begin
         tick_cnt <= 2'd0;
         i_s_tick <= 1'b0;
      end else begin
         tick_cnt <= tick_cnt + 2'd1;
         i_s_tick <= (tick_cnt == 2'd3);
      end
   end

   int cycle = 0;
   always @(posedge i_clk) cycle <= cycle + 1;

   logic [7:0] rx_q[$];
   logic       ferr_q[$];
   int         done_cycle = 0;
   int         fall_cycle = 0;
   int         stray_ferr = 0;

   always @(negedge i_clk) begin
      if (o_rx_done) begin
         rx_q.push_back(o_data);
         ferr_q.push_back(o_frame_err);
         done_cycle = cycle;
         $display("rx  data=0x%02h frame_err=%0b at cycle %0d", o_data, o_frame_err, cycle);
      end
      if (o_frame_err && !o_rx_done) stray_ferr++;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      int guard = 0;
      while (seen < n) begin
         @(posedge i_clk);
         if (i_s_tick) seen++;
         guard++;
         if (guard > n * 8 + 200) begin
            check("tick_timeout", 32'd0, 32'd1);
            break;
         end
      end
      #1;
   endtask

   task automatic send_bit(input logic b, input int ticks);
      i_rx = b;
      wait_ticks(ticks);
   endtask

   task automatic idle_ticks(input int n);
      send_bit(1'b1, n);
   endtask

   // Caller must be tick-aligned; stall_bit < 0 means no tick stall.
   task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stall_bit);
      $display("tx  data=0x%02h stop=%0b stall_bit=%0d", d, stop_val, stall_bit);
      fall_cycle = cycle;
      send_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (i == stall_bit) begin
            i_rx = d[i];
            wait_ticks(5);
            tick_en = 1'b0;
            repeat (100) @(posedge i_clk);
            #1;
            tick_en = 1'b1;
            wait_ticks(11);
         end else begin
            send_bit(d[i], 16);
         end
      end
      if (stop_val) begin
         send_bit(1'b1, 16);
      end else begin
         // Low stop bit released early so the mid-start recheck rejects it.
         send_bit(1'b0, 12);
         i_rx = 1'b1;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      tick_en = 1'b1;
      i_reset = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_data", {24'd0, o_data}, 32'h00);
      check("reset_done", {31'd0, o_rx_done}, 32'd0);
      check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
      i_reset = 1'b0;
      idle_ticks(4);

      // Single frame and latency from start-bit falling edge.
      send_frame(8'h55, 1'b1, -1);
      idle_ticks(32);
      lat = done_cycle - fall_cycle;
      check("f55_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         check("f55_data", {24'd0, rx_q[0]}, 32'h55);
         check("f55_ferr", {31'd0, ferr_q[0]}, 32'd0);
      end
      check("f55_latency", {31'd0, (lat >= 606 && lat <= 614)}, 32'd1);
      rx_q.delete(); ferr_q.delete();

      // Back-to-back frames with no idle gap.
      send_frame(8'hA5, 1'b1, -1);
      send_frame(8'h3C, 1'b1, -1);
      idle_ticks(32);
      check("b2b_count", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) begin
         check("b2b_data0", {24'd0, rx_q[0]}, 32'hA5);
         check("b2b_data1", {24'd0, rx_q[1]}, 32'h3C);
         check("b2b_ferr", {30'd0, ferr_q[0], ferr_q[1]}, 32'd0);
      end
      rx_q.delete(); ferr_q.delete();

      // Three-tick low glitch on the idle line.
      $display("tx  glitch 3 ticks");
      send_bit(1'b0, 3);
      idle_ticks(32);
      check("glitch_count", rx_q.size(), 32'd0);
      check("glitch_hold", {24'd0, o_data}, 32'h3C);
      rx_q.delete(); ferr_q.delete();

      // Framing error: stop bit sampled low.
      send_frame(8'hF0, 1'b0, -1);
      idle_ticks(32);
      check("ferr_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         check("ferr_data", {24'd0, rx_q[0]}, 32'hF0);
         check("ferr_flag", {31'd0, ferr_q[0]}, 32'd1);
      end
      check("ferr_hold", {24'd0, o_data}, 32'hF0);
      rx_q.delete(); ferr_q.delete();

      // Reset in the middle of the data bits of 0x81.
      $display("tx  data=0x81 aborted by reset");
      send_bit(1'b0, 16);
      send_bit(1'b1, 16);
      send_bit(1'b0, 16);
      send_bit(1'b0, 8);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_rx = 1'b1;
      check("midrst_data", {24'd0, o_data}, 32'h00);
      idle_ticks(32);
      send_frame(8'h42, 1'b1, -1);
      idle_ticks(32);
      check("midrst_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         check("midrst_val", {24'd0, rx_q[0]}, 32'h42);
         check("midrst_ferr", {31'd0, ferr_q[0]}, 32'd0);
      end
      rx_q.delete(); ferr_q.delete();

      // 100-cycle tick stall inside data bit 3.
      send_frame(8'h99, 1'b1, 3);
      idle_ticks(32);
      check("stall_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         check("stall_data", {24'd0, rx_q[0]}, 32'h99);
         check("stall_ferr", {31'd0, ferr_q[0]}, 32'd0);
      end

      check("stray_ferr", stray_ferr, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
